// File: rtl/mmu_sequencer_pkg.sv
// rtl/mmu_sequencer_pkg.sv - shared parameters, state encoding and timing constants for the MMU sequencer
package mmu_sequencer_pkg;

  localparam int DIM     = 16;
  localparam int DATA_W  = 8;
  localparam int ADDR_W  = 8;
  localparam int ACC_W   = 20;
  localparam int MMU_LAT = 16;

  // One extra bit so a full-range num_rows never wraps the counter
  localparam int CNT_W = ADDR_W + 1;

  // Read latency + input skew + array latency + output skew
  localparam int DRAIN_CYCLES = 1 + (DIM - 1) + MMU_LAT + (DIM - 1);

  // Vector-valid shift pipeline; col_valid taps the top DIM stages
  localparam int VPIPE_LEN = MMU_LAT + DIM;

  localparam int clock_period      = 10;
  localparam int half_clock_period = clock_period / 2;
  localparam int minimum_period    = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mmu_sequencer_if.sv
// rtl/mmu_sequencer_if.sv - job control, buffer read and MMU drive signals of the sequencer
interface mmu_sequencer_if import mmu_sequencer_pkg::*; ();

  logic                     start;
  logic                     skip_wload;
  logic [ADDR_W-1:0]        num_rows;
  logic                     busy;
  logic                     done;
  logic                     w_rd_en;
  logic [ADDR_W-1:0]        w_rd_addr;
  logic [DIM*DATA_W-1:0]    w_rd_data;
  logic                     a_rd_en;
  logic [ADDR_W-1:0]        a_rd_addr;
  logic [DIM*DATA_W-1:0]    a_rd_data;
  logic                     mmu_wen;
  logic [DIM*DATA_W-1:0]    mmu_win;
  logic [DIM*DATA_W-1:0]    mmu_ain;
  logic [DIM-1:0]           col_valid;

  // Sequencer side
  modport slave (
    input  start, skip_wload, num_rows, w_rd_data, a_rd_data,
    output busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           mmu_wen, mmu_win, mmu_ain, col_valid
  );

  // Job issuer / buffer / MMU side
  modport master (
    output start, skip_wload, num_rows, w_rd_data, a_rd_data,
    input  busy, done, w_rd_en, w_rd_addr, a_rd_en, a_rd_addr,
           mmu_wen, mmu_win, mmu_ain, col_valid
  );

endinterface

// File: rtl/mmu_skew_buffer.sv
// rtl/mmu_skew_buffer.sv - triangular delay array: lane i leaves i cycles after lane 0
module mmu_skew_buffer #(
  parameter int DIM    = 16,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic [DIM*DATA_W-1:0] i_row,
  output logic [DIM*DATA_W-1:0] o_lanes
);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DATA_W-1:0] r_pipe [i+1];

    // Capture the lane (zero when no row enters) and shift it down an i-deep chain
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        for (int d = 0; d <= i; d++) r_pipe[d] <= '0;
      end else begin
        r_pipe[0] <= i_valid ? i_row[i*DATA_W +: DATA_W] : '0;
        for (int d = 1; d <= i; d++) r_pipe[d] <= r_pipe[d-1];
      end
    end

    assign o_lanes[i*DATA_W +: DATA_W] = r_pipe[i];
  end

endmodule

// File: rtl/mmu_sequencer.sv
// rtl/mmu_sequencer.sv - weight preload, skewed activation streaming and drain sequencing for the 16x16 MMU
module mmu_sequencer import mmu_sequencer_pkg::*; (
  input  logic          clk,
  input  logic          reset_n,
  mmu_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] C_DIM       = CNT_W'(DIM);
  localparam logic [CNT_W-1:0] C_DRAIN_END = CNT_W'(DRAIN_CYCLES - 1);

  seq_state_t             r_state;
  seq_state_t             w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [ADDR_W-1:0]      r_num_rows;
  logic [CNT_W-1:0]       w_rows_ext;
  logic                   w_w_rd_en;
  logic                   w_a_rd_en;
  logic                   r_mmu_wen;
  logic                   r_a_vld;
  logic [VPIPE_LEN-1:0]   r_vpipe;

  assign w_rows_ext = {1'b0, r_num_rows};

  // State, phase counter and the job's row count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_num_rows <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_IDLE && bus.start) r_num_rows <= bus.num_rows;
    end
  end

  // Next state, counter advance and buffer read strobes
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_w_rd_en  = 1'b0;
    w_a_rd_en  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_next = '0;
        if (bus.start) begin
          if (!bus.skip_wload)          w_next = S_LOAD_W;
          else if (bus.num_rows != '0)  w_next = S_STREAM;
          else                          w_next = S_DRAIN;
        end
      end
      S_LOAD_W: begin
        // Extra final cycle lets the last registered wen retire before leaving
        w_w_rd_en  = (r_cnt < C_DIM);
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == C_DIM) begin
          w_cnt_next = '0;
          w_next     = (r_num_rows != '0) ? S_STREAM : S_DRAIN;
        end
      end
      S_STREAM: begin
        w_a_rd_en  = 1'b1;
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == w_rows_ext - 1'b1) begin
          w_cnt_next = '0;
          w_next     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == C_DRAIN_END) begin
          w_cnt_next = '0;
          w_next     = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Align wen with returned weight data and track rows returning from the activation buffer
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mmu_wen <= 1'b0;
      r_a_vld   <= 1'b0;
      r_vpipe   <= '0;
    end else begin
      r_mmu_wen <= w_w_rd_en;
      r_a_vld   <= w_a_rd_en;
      r_vpipe   <= {r_vpipe[VPIPE_LEN-2:0], r_a_vld};
    end
  end

  mmu_skew_buffer #(
    .DIM    (DIM),
    .DATA_W (DATA_W)
  ) u_skew (
    .clk     (clk),
    .reset_n (reset_n),
    .i_valid (r_a_vld),
    .i_row   (bus.a_rd_data),
    .o_lanes (bus.mmu_ain)
  );

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.w_rd_en   = w_w_rd_en;
  assign bus.w_rd_addr = w_w_rd_en ? r_cnt[ADDR_W-1:0] : '0;
  assign bus.a_rd_en   = w_a_rd_en;
  assign bus.a_rd_addr = w_a_rd_en ? r_cnt[ADDR_W-1:0] : '0;
  assign bus.mmu_wen   = r_mmu_wen;
  assign bus.mmu_win   = r_mmu_wen ? bus.w_rd_data : '0;
  assign bus.col_valid = r_vpipe[MMU_LAT +: DIM];

endmodule

// File: tb/tb_mmu_sequencer.sv
// tb/tb_mmu_sequencer.sv - scoreboard bench for the MMU sequencer
module tb_mmu_sequencer import mmu_sequencer_pkg::*; ();

  typedef struct {
    int                    cyc;
    logic [DIM*DATA_W-1:0] val;
  } ent_t;

  logic clk;
  logic reset_n;
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_fail = 0;
  bit   mon_en = 0;
  int   busy_run = 0;

  logic [DIM*DATA_W-1:0] w_mem [DIM];
  logic [DIM*DATA_W-1:0] a_mem [DIM];

  ent_t q_wrd[$];
  ent_t q_ard[$];
  ent_t q_wen[$];
  ent_t q_ain[$];
  ent_t q_cv[$];
  ent_t q_done[$];
  ent_t q_busy[$];

  mmu_sequencer_if bus();

  mmu_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #(half_clock_period) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous buffers: data one cycle after the read enable
  always @(posedge clk) begin
    if (bus.w_rd_en) bus.w_rd_data <= w_mem[bus.w_rd_addr[3:0]];
    if (bus.a_rd_en) bus.a_rd_data <= a_mem[bus.a_rd_addr[3:0]];
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic compare_ev(input string name, input bit have, input ent_t exp,
                            input int acyc, input logic [127:0] aval);
    n_vec++;
    if (!have) begin
      n_fail++;
      $display("FAIL %s: unexpected event at cycle %0d value %h, none required", name, acyc, aval);
    end else if (exp.cyc != acyc || exp.val !== aval) begin
      n_fail++;
      $display("FAIL %s: got cycle %0d value %h, required cycle %0d value %h",
               name, acyc, aval, exp.cyc, exp.val);
    end
  endtask

  // Monitor: every observed DUT event is matched against the head of its queue
  ent_t m_e;
  bit   m_have;
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.w_rd_en) begin
        m_have = q_wrd.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_wrd.pop_front();
        compare_ev("w_rd", m_have, m_e, cyc, 128'(bus.w_rd_addr));
      end
      if (bus.a_rd_en) begin
        m_have = q_ard.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_ard.pop_front();
        compare_ev("a_rd", m_have, m_e, cyc, 128'(bus.a_rd_addr));
      end
      if (bus.mmu_wen) begin
        m_have = q_wen.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_wen.pop_front();
        compare_ev("wen_win", m_have, m_e, cyc, bus.mmu_win);
      end
      if (bus.mmu_ain != '0) begin
        m_have = q_ain.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_ain.pop_front();
        compare_ev("ain", m_have, m_e, cyc, bus.mmu_ain);
      end
      if (bus.col_valid != '0) begin
        m_have = q_cv.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_cv.pop_front();
        compare_ev("col_valid", m_have, m_e, cyc, 128'(bus.col_valid));
      end
      if (bus.done) begin
        m_have = q_done.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_done.pop_front();
        compare_ev("done", m_have, m_e, cyc, '0);
      end
      if (bus.busy) begin
        busy_run++;
      end else if (busy_run > 0) begin
        m_have = q_busy.size() > 0; m_e = '{cyc: -1, val: '0};
        if (m_have) m_e = q_busy.pop_front();
        compare_ev("busy_len", m_have, m_e, busy_run, '0);
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected event stream for a full job whose start is high in cycle s
  task automatic expect_job(input int s, input bit skip, input int n);
    int st;
    int ds;
    int base;
    int r;
    logic [DIM*DATA_W-1:0] v;
    if (!skip) begin
      for (int k = 0; k < DIM; k++) begin
        q_wrd.push_back('{cyc: s + 1 + k, val: 128'(k)});
        q_wen.push_back('{cyc: s + 2 + k, val: w_mem[k]});
      end
      st = s + DIM + 2;
    end else begin
      st = s + 1;
    end
    for (int k = 0; k < n; k++) q_ard.push_back('{cyc: st + k, val: 128'(k)});
    if (n > 0) begin
      for (int t = st + 2; t <= st + 2 + (n - 1) + (DIM - 1); t++) begin
        v = '0;
        for (int i = 0; i < DIM; i++) begin
          r = t - st - 2 - i;
          if (r >= 0 && r < n) v[i*DATA_W +: DATA_W] = a_mem[r][i*DATA_W +: DATA_W];
        end
        if (v != '0) q_ain.push_back('{cyc: t, val: v});
      end
      base = st + 2 + MMU_LAT;
      for (int t = base; t <= base + n + DIM - 2; t++) begin
        v = '0;
        for (int j = 0; j < DIM; j++) begin
          r = t - base - j;
          if (r >= 0 && r < n) v[j] = 1'b1;
        end
        q_cv.push_back('{cyc: t, val: 128'(v[DIM-1:0])});
      end
    end
    ds = st + n;
    q_done.push_back('{cyc: ds + DRAIN_CYCLES, val: '0});
    q_busy.push_back('{cyc: ds + DRAIN_CYCLES - s, val: '0});
  endtask

  task automatic issue(input bit skip, input int n, input bit push, output int s);
    tick();
    bus.start      = 1'b1;
    bus.skip_wload = skip;
    bus.num_rows   = ADDR_W'(n);
    s = cyc;
    if (push) expect_job(s, skip, n);
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!bus.busy) begin
        ok = 1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_fail++;
      $display("FAIL idle_timeout: busy %0d after %0d cycles, required 0", bus.busy, limit);
    end
  endtask

  initial begin
    #(clock_period * 20000);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d, required completion", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    reset_n        = 1'b0;
    bus.start      = 1'b0;
    bus.skip_wload = 1'b0;
    bus.num_rows   = '0;
    for (int k = 0; k < DIM; k++)
      for (int i = 0; i < DIM; i++) w_mem[k][i*DATA_W +: DATA_W] = 8'(k + 1);
    for (int k = 0; k < DIM; k++)
      for (int i = 0; i < DIM; i++) a_mem[k][i*DATA_W +: DATA_W] = 8'(k + 1);

    repeat (3) tick();
    @(negedge clk);
    check("reset_state",
          {bus.busy, bus.done, bus.w_rd_en, bus.a_rd_en, bus.mmu_wen, bus.col_valid,
           bus.mmu_ain != '0, bus.w_rd_addr, bus.a_rd_addr}, '0);
    mon_en = 1;

    // start together with reset: reset wins
    tick();
    bus.start = 1'b1; bus.skip_wload = 1'b1; bus.num_rows = 8'd3;
    tick();
    reset_n = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    check("start_during_reset_busy", {bus.busy, bus.a_rd_en}, '0);

    // Job A: full load, four rows; a stray start mid-stream must be ignored
    issue(1'b0, 4, 1'b1, s);
    while (cyc < s + 20) tick();
    bus.start = 1'b1; bus.skip_wload = 1'b1; bus.num_rows = 8'd5;
    tick();
    bus.start = 1'b0;
    wait_idle(200);

    // Job B: skew check with row 0 = -1..-16
    for (int i = 0; i < DIM; i++) a_mem[0][i*DATA_W +: DATA_W] = 8'(255 - i);
    issue(1'b1, 1, 1'b1, s);
    wait_idle(200);

    // Job C: resident weights, two rows
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DIM; i++) a_mem[k][i*DATA_W +: DATA_W] = 8'(16 * (k + 1) + i);
    issue(1'b1, 2, 1'b1, s);
    wait_idle(200);

    // Job D: nothing to stream
    issue(1'b1, 0, 1'b1, s);
    wait_idle(200);

    // Job E: reset during weight load after seven wen cycles
    issue(1'b0, 4, 1'b0, s);
    for (int k = 0; k < 8; k++) q_wrd.push_back('{cyc: s + 1 + k, val: 128'(k)});
    for (int k = 0; k < 7; k++) q_wen.push_back('{cyc: s + 2 + k, val: w_mem[k]});
    q_busy.push_back('{cyc: 8, val: '0});
    while (cyc < s + 8) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    check("abort_wen_busy", {bus.mmu_wen, bus.busy, bus.w_rd_en}, '0);

    // Job F: fresh full load with new weights, three rows
    for (int k = 0; k < DIM; k++)
      for (int i = 0; i < DIM; i++) w_mem[k][i*DATA_W +: DATA_W] = 8'(200 - 3 * k + i);
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < DIM; i++) a_mem[k][i*DATA_W +: DATA_W] = 8'(40 * k + 3 * i + 7);
    issue(1'b0, 3, 1'b1, s);
    wait_idle(200);

    repeat (3) tick();
    check("left_w_rd",      128'(q_wrd.size()),  '0);
    check("left_a_rd",      128'(q_ard.size()),  '0);
    check("left_wen",       128'(q_wen.size()),  '0);
    check("left_ain",       128'(q_ain.size()),  '0);
    check("left_col_valid", 128'(q_cv.size()),   '0);
    check("left_done",      128'(q_done.size()), '0);
    check("left_busy",      128'(q_busy.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
